// File: rtl/rtx_pkg.sv
// Shared ray-tracer definitions: screen geometry, colour payload, scheduler state codes.
package rtx_pkg;

    localparam int unsigned SCREEN_WIDTH  = 1280;
    localparam int unsigned SCREEN_HEIGHT = 720;

    localparam int unsigned FP24_W  = 24;
    localparam int unsigned PIX_H_W = 11;
    localparam int unsigned PIX_V_W = 10;

    // Three-component colour/vector in 24-bit floating point
    typedef struct packed {
        logic [FP24_W-1:0] x;
        logic [FP24_W-1:0] y;
        logic [FP24_W-1:0] z;
    } fp24_vec3;

    // Frame-level FSM encoding
    localparam logic [1:0] FRM_IDLE  = 2'd0;
    localparam logic [1:0] FRM_RUN   = 2'd1;
    localparam logic [1:0] FRM_DRAIN = 2'd2;
    localparam logic [1:0] FRM_DONE  = 2'd3;

    // Per-core occupancy encoding
    localparam logic [1:0] CORE_FREE = 2'd0;
    localparam logic [1:0] CORE_BUSY = 2'd1;
    localparam logic [1:0] CORE_HOLD = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates past the last accepted grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         accept_i,
    output logic [N-1:0] grant_c
);

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found_c;
    int unsigned      idx_c;

    // Search requests starting at the pointer; advance only when the grant is taken
    always_comb begin
        grant_c = '0;
        ptr_d   = ptr_q;
        found_c = 1'b0;
        idx_c   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx_c = (32'(ptr_q) + k) % N;
            if (!found_c && req_i[IDX_W'(idx_c)]) begin
                found_c                 = 1'b1;
                grant_c[IDX_W'(idx_c)]  = 1'b1;
                ptr_d                   = (idx_c + 1 == N) ? '0 : IDX_W'(idx_c + 1);
            end
        end
        if (!accept_i) begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rtx_scheduler.sv
// Frame scheduler: hands pixels to ray_tracer cores in raster order and
// funnels their results into the framebuffer one write at a time.
module rtx_scheduler
    import rtx_pkg::*;
#(
    parameter int unsigned WIDTH     = SCREEN_WIDTH,
    parameter int unsigned HEIGHT    = SCREEN_HEIGHT,
    parameter int unsigned NUM_CORES = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic [NUM_CORES-1:0]                 core_ray_valid,
    output logic [NUM_CORES-1:0][PIX_H_W-1:0]    core_pixel_h,
    output logic [NUM_CORES-1:0][PIX_V_W-1:0]    core_pixel_v,
    input  logic [NUM_CORES-1:0]                 core_ray_done,
    input  fp24_vec3 [NUM_CORES-1:0]             core_pixel_color,
    output logic                                 fb_we,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]      fb_addr,
    output fp24_vec3                             fb_color,
    input  logic                                 fb_ready
);

    localparam int unsigned ADDR_W = $clog2(WIDTH*HEIGHT);
    localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [1:0]                              frm_q, frm_d;
    logic [PIX_H_W-1:0]                      h_q, h_d;
    logic [PIX_V_W-1:0]                      v_q, v_d;
    logic [NUM_CORES-1:0][1:0]               cst_q, cst_d;
    logic [NUM_CORES-1:0]                    valid_q, valid_d;
    logic [NUM_CORES-1:0][PIX_H_W-1:0]       ph_q, ph_d;
    logic [NUM_CORES-1:0][PIX_V_W-1:0]       pv_q, pv_d;
    fp24_vec3 [NUM_CORES-1:0]                hold_q, hold_d;
    logic                                    busy_q, busy_d;
    logic                                    done_q, done_d;
    logic                                    we_q, we_d;
    logic [ADDR_W-1:0]                       addr_q, addr_d;
    fp24_vec3                                col_q, col_d;
    logic [IDX_W-1:0]                        own_q, own_d;

    logic                                    xfer_c;
    logic                                    accept_c;
    logic [NUM_CORES-1:0]                    req_c;
    logic [NUM_CORES-1:0]                    grant_c;
    logic                                    free_found_c;
    logic                                    all_free_c;
    logic [IDX_W-1:0]                        gidx_c;

    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign core_ray_valid = valid_q;
    assign core_pixel_h   = ph_q;
    assign core_pixel_v   = pv_q;
    assign fb_we          = we_q;
    assign fb_addr        = addr_q;
    assign fb_color       = col_q;

    // Held results compete for the write port; the core already being written is excluded
    always_comb begin
        xfer_c = we_q && fb_ready;
        req_c  = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            req_c[i] = (cst_q[i] == CORE_HOLD) && !(we_q && (own_q == IDX_W'(i)));
        end
        accept_c = (!we_q || fb_ready) && (|req_c);
    end

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_c),
        .accept_i (accept_c),
        .grant_c  (grant_c)
    );

    // Next-state logic: frame FSM, dispatch, completion capture and write issue
    always_comb begin
        frm_d        = frm_q;
        h_d          = h_q;
        v_d          = v_q;
        cst_d        = cst_q;
        valid_d      = '0;
        ph_d         = ph_q;
        pv_d         = pv_q;
        hold_d       = hold_q;
        we_d         = we_q;
        addr_d       = addr_q;
        col_d        = col_q;
        own_d        = own_q;
        free_found_c = 1'b0;
        all_free_c   = 1'b1;
        gidx_c       = '0;

        // Dispatch the current pixel to the lowest-index free core
        if (frm_q == FRM_RUN) begin
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (!free_found_c && (cst_q[i] == CORE_FREE)) begin
                    free_found_c = 1'b1;
                    cst_d[i]     = CORE_BUSY;
                    valid_d[i]   = 1'b1;
                    ph_d[i]      = h_q;
                    pv_d[i]      = v_q;
                end
            end
            if (free_found_c) begin
                if (h_q == PIX_H_W'(WIDTH - 1)) begin
                    h_d = '0;
                    if (v_q == PIX_V_W'(HEIGHT - 1)) begin
                        v_d   = '0;
                        frm_d = FRM_DRAIN;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
        end

        // Capture every completion from a busy core; others are stray and ignored
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (core_ray_done[i] && (cst_q[i] == CORE_BUSY)) begin
                cst_d[i]  = CORE_HOLD;
                hold_d[i] = core_pixel_color[i];
            end
        end

        // Completed transfer releases the owning core
        if (xfer_c) begin
            we_d = 1'b0;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (own_q == IDX_W'(i)) begin
                    cst_d[i] = CORE_FREE;
                end
            end
        end

        // New grant may overlap a completing transfer
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (grant_c[i]) begin
                gidx_c = IDX_W'(i);
            end
        end
        if (accept_c) begin
            we_d   = 1'b1;
            own_d  = gidx_c;
            addr_d = ADDR_W'(32'(pv_q[gidx_c]) * 32'(WIDTH) + 32'(ph_q[gidx_c]));
            col_d  = hold_q[gidx_c];
        end

        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (cst_q[i] != CORE_FREE) begin
                all_free_c = 1'b0;
            end
        end

        case (frm_q)
            FRM_IDLE: begin
                if (start) begin
                    frm_d = FRM_RUN;
                    h_d   = '0;
                    v_d   = '0;
                end
            end
            FRM_DRAIN: begin
                if (all_free_c && !we_q) begin
                    frm_d = FRM_DONE;
                end
            end
            FRM_DONE: begin
                frm_d = FRM_IDLE;
            end
            default: begin
            end
        endcase

        busy_d = (frm_d == FRM_RUN) || (frm_d == FRM_DRAIN);
        done_d = (frm_d == FRM_DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q   <= FRM_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            cst_q   <= '0;
            valid_q <= '0;
            ph_q    <= '0;
            pv_q    <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            col_q   <= '0;
            own_q   <= '0;
        end else begin
            frm_q   <= frm_d;
            h_q     <= h_d;
            v_q     <= v_d;
            cst_q   <= cst_d;
            valid_q <= valid_d;
            ph_q    <= ph_d;
            pv_q    <= pv_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            own_q   <= own_d;
        end
    end

endmodule

// File: tb/tb_rtx_scheduler.sv
// Directed bench for rtx_scheduler on a 4x2 frame: two-core and one-core instances.
`timescale 1ns/1ps
module tb_rtx_scheduler;
    import rtx_pkg::*;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 2;
    localparam int unsigned NPIX = W * H;
    localparam int unsigned AW   = $clog2(W * H);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-core instance
    logic                   a_rst, a_start, a_busy, a_fdone, a_we, a_ready;
    logic [1:0]             a_valid, a_done;
    logic [1:0][10:0]       a_ph;
    logic [1:0][9:0]        a_pv;
    fp24_vec3 [1:0]         a_color;
    logic [AW-1:0]          a_addr;
    fp24_vec3               a_fcol;

    // One-core instance
    logic                   b_rst, b_start, b_busy, b_fdone, b_we, b_ready;
    logic [0:0]             b_valid, b_done;
    logic [0:0][10:0]       b_ph;
    logic [0:0][9:0]        b_pv;
    fp24_vec3 [0:0]         b_color;
    logic [AW-1:0]          b_addr;
    fp24_vec3               b_fcol;

    rtx_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(2)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .busy(a_busy), .frame_done(a_fdone),
        .core_ray_valid(a_valid), .core_pixel_h(a_ph), .core_pixel_v(a_pv),
        .core_ray_done(a_done), .core_pixel_color(a_color),
        .fb_we(a_we), .fb_addr(a_addr), .fb_color(a_fcol), .fb_ready(a_ready)
    );

    rtx_scheduler #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(1)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .busy(b_busy), .frame_done(b_fdone),
        .core_ray_valid(b_valid), .core_pixel_h(b_ph), .core_pixel_v(b_pv),
        .core_ray_done(b_done), .core_pixel_color(b_color),
        .fb_we(b_we), .fb_addr(b_addr), .fb_color(b_fcol), .fb_ready(b_ready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int color_salt = 0;

    // Two-core model and scoreboard
    int       a_lat [2];
    int       a_cnt [2];
    int       a_hh [2];
    int       a_vv [2];
    fp24_vec3 a_exp [NPIX];
    bit       a_wr [NPIX];
    int       a_seq [NPIX];
    int       a_seq_cyc [NPIX];
    int       a_wr_cnt, a_fd_cnt, a_next, a_disp_cnt, a_first_h, a_first_v;
    bit       a_ordered, a_both_done;

    // One-core model and scoreboard
    int       b_cnt, b_hh, b_vv, b_done_addr, b_dn, b_wr_cnt, b_fd_cnt, b_next;
    fp24_vec3 b_exp;

    localparam logic [71:0] GARBAGE = 72'hBADBADBADDEADBEEF0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic fp24_vec3 mkcolor(input int core, input int h, input int v, input int salt);
        fp24_vec3 c;
        c.x = 24'h3F0000 | 24'(h);
        c.y = 24'h400000 | 24'(v);
        c.z = 24'(salt * 256 + core * 64 + v * 8 + h);
        return c;
    endfunction

    task automatic a_on_write(input int ad, input fp24_vec3 c);
        check("a_addr_range", 1'(ad < int'(NPIX)), 1'b1);
        if (ad < int'(NPIX)) begin
            check("a_color", c, a_exp[ad]);
            check("a_once", a_wr[ad], 1'b0);
            a_wr[ad] = 1'b1;
        end
        if (a_ordered) check("a_order", ad, a_next);
        if (a_wr_cnt < int'(NPIX)) begin
            a_seq[a_wr_cnt]     = ad;
            a_seq_cyc[a_wr_cnt] = cyc;
        end
        a_wr_cnt++;
        a_next++;
    endtask

    task automatic b_on_write(input int ad, input fp24_vec3 c);
        check("b_order", ad, b_next);
        check("b_addr_hv", ad, b_done_addr);
        check("b_color", c, b_exp);
        b_wr_cnt++;
        b_next++;
    endtask

    // One clock: inputs set by the caller hold through the coming posedge
    task automatic cycle();
        bit       a_x, b_x;
        int       a_ad, b_ad;
        fp24_vec3 a_c, b_c;
        a_x  = a_we && a_ready;
        a_ad = int'(a_addr);
        a_c  = a_fcol;
        b_x  = b_we && b_ready;
        b_ad = int'(b_addr);
        b_c  = b_fcol;
        @(negedge clk);
        cyc++;
        if (a_x) a_on_write(a_ad, a_c);
        if (b_x) b_on_write(b_ad, b_c);
        if (a_fdone) a_fd_cnt++;
        if (b_fdone) b_fd_cnt++;
        for (int i = 0; i < 2; i++) begin
            a_done[i]  = 1'b0;
            a_color[i] = fp24_vec3'(GARBAGE);
            if (a_valid[i]) begin
                if (a_disp_cnt == 0) begin
                    a_first_h = int'(a_ph[i]);
                    a_first_v = int'(a_pv[i]);
                end
                a_disp_cnt++;
                a_cnt[i] = a_lat[i];
                a_hh[i]  = int'(a_ph[i]);
                a_vv[i]  = int'(a_pv[i]);
            end else if (a_cnt[i] > 0) begin
                a_cnt[i]--;
                if (a_cnt[i] == 0) begin
                    a_done[i]  = 1'b1;
                    a_color[i] = mkcolor(i, a_hh[i], a_vv[i], color_salt);
                    if (a_vv[i] * int'(W) + a_hh[i] < int'(NPIX))
                        a_exp[a_vv[i] * int'(W) + a_hh[i]] = a_color[i];
                end
            end
        end
        if (a_done == 2'b11) a_both_done = 1'b1;
        b_done[0]  = 1'b0;
        b_color[0] = fp24_vec3'(GARBAGE);
        if (b_valid[0]) begin
            check("b_disp_h", b_ph[0], b_dn % int'(W));
            check("b_disp_v", b_pv[0], b_dn / int'(W));
            b_dn++;
            b_hh  = int'(b_ph[0]);
            b_vv  = int'(b_pv[0]);
            b_cnt = int'($urandom_range(20, 1));
        end else if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) begin
                b_done[0]   = 1'b1;
                b_color[0]  = mkcolor(0, b_hh, b_vv, color_salt);
                b_exp       = b_color[0];
                b_done_addr = b_vv * int'(W) + b_hh;
            end
        end
    endtask

    task automatic a_init(input int l0, input int l1, input bit ordered);
        a_lat[0] = l0; a_lat[1] = l1;
        a_cnt[0] = 0;  a_cnt[1] = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            a_wr[i] = 1'b0; a_seq[i] = -1; a_seq_cyc[i] = 0;
        end
        a_wr_cnt = 0; a_fd_cnt = 0; a_next = 0; a_disp_cnt = 0;
        a_first_h = -1; a_first_v = -1;
        a_ordered = ordered; a_both_done = 1'b0;
        color_salt++;
    endtask

    task automatic a_frame_start();
        a_start = 1'b1;
        cycle();
        a_start = 1'b0;
    endtask

    task automatic run_a(input int budget);
        int n;
        n = 0;
        while (a_fd_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        check("a_timeout", 1'(a_fd_cnt == 0), 1'b0);
    endtask

    task automatic a_end(input string tag);
        int n;
        n = 0;
        repeat (3) cycle();
        for (int i = 0; i < int'(NPIX); i++) if (a_wr[i]) n++;
        check({tag, "_writes"}, a_wr_cnt, NPIX);
        check({tag, "_addrs"}, n, NPIX);
        check({tag, "_disp"}, a_disp_cnt, NPIX);
        check({tag, "_fdone"}, a_fd_cnt, 1);
        check({tag, "_busy"}, a_busy, 1'b0);
    endtask

    task automatic a_reset();
        a_rst = 1'b1;
        cycle();
        a_rst = 1'b0;
        a_cnt[0] = 0; a_cnt[1] = 0;
        a_done = '0;
    endtask

    initial begin
        int n;
        a_rst = 1'b1; a_start = 1'b0; a_ready = 1'b1; a_done = '0; a_color = '0;
        b_rst = 1'b1; b_start = 1'b0; b_ready = 1'b1; b_done = '0; b_color = '0;
        a_init(5, 5, 1'b1);
        b_cnt = 0; b_dn = 0; b_wr_cnt = 0; b_fd_cnt = 0; b_next = 0; b_done_addr = -1;
        b_exp = '0; b_hh = 0; b_vv = 0;
        cycle();
        cycle();

        // Reset state
        check("rst_busy",  a_busy,  1'b0);
        check("rst_fdone", a_fdone, 1'b0);
        check("rst_valid", a_valid, 2'b00);
        check("rst_we",    a_we,    1'b0);
        check("rst_ph",    a_ph,    22'd0);
        check("rst_pv",    a_pv,    20'd0);
        check("rst_addr",  a_addr,  3'd0);
        check("rst_fcol",  a_fcol,  72'd0);
        check("rst_b_busy", b_busy, 1'b0);
        check("rst_b_we",   b_we,   1'b0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        cycle();

        // Full frame, fixed 5-cycle latency, framebuffer always ready
        a_init(5, 5, 1'b1);
        a_frame_start();
        check("t1_busy_on", a_busy, 1'b1);
        run_a(300);
        a_end("t1");

        // Simultaneous completion from both cores right after reset
        a_reset();
        a_init(6, 5, 1'b0);
        a_frame_start();
        run_a(300);
        check("t2_both_done", a_both_done, 1'b1);
        check("t2_first",  a_seq[0], 0);
        check("t2_second", a_seq[1], 1);
        check("t2_consec", a_seq_cyc[1] - a_seq_cyc[0], 1);
        a_end("t2");

        // Framebuffer stall for 10 cycles on the first write
        a_init(5, 5, 1'b0);
        a_frame_start();
        n = 0;
        while (!a_we && n < 50) begin
            cycle();
            n++;
        end
        check("t3_we_seen", a_we, 1'b1);
        check("t3_addr0", a_addr, 3'd0);
        a_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("t3_hold_we",   a_we,      1'b1);
            check("t3_hold_addr", a_addr,    3'd0);
            check("t3_hold_col",  a_fcol,    a_exp[0]);
            check("t3_no_disp0",  a_valid[0], 1'b0);
        end
        check("t3_no_xfer", a_wr_cnt, 0);
        a_ready = 1'b1;
        run_a(300);
        a_end("t3");

        // Start pulsed mid-frame is ignored
        a_init(5, 5, 1'b1);
        a_frame_start();
        repeat (6) cycle();
        check("t4_busy_mid", a_busy, 1'b1);
        a_start = 1'b1;
        cycle();
        a_start = 1'b0;
        run_a(300);
        a_end("t4");

        // Reset after pixel 3 dispatch abandons the frame; next frame restarts at (0,0)
        a_init(5, 5, 1'b1);
        a_frame_start();
        n = 0;
        while (a_disp_cnt < 4 && n < 50) begin
            cycle();
            n++;
        end
        check("t5_reached_px3", a_disp_cnt, 4);
        a_reset();
        check("t5_busy_rst",  a_busy,  1'b0);
        check("t5_valid_rst", a_valid, 2'b00);
        check("t5_we_rst",    a_we,    1'b0);
        repeat (15) cycle();
        check("t5_no_fdone", a_fd_cnt, 0);
        a_init(5, 5, 1'b1);
        a_frame_start();
        run_a(300);
        check("t5_first_h", a_first_h, 0);
        check("t5_first_v", a_first_v, 0);
        a_end("t5");

        // Single core with random latency: raster-order writes, addr = v*4+h
        color_salt++;
        b_start = 1'b1;
        cycle();
        b_start = 1'b0;
        n = 0;
        while (b_fd_cnt == 0 && n < 600) begin
            cycle();
            n++;
        end
        check("b_timeout", 1'(b_fd_cnt == 0), 1'b0);
        repeat (3) cycle();
        check("b_writes", b_wr_cnt, NPIX);
        check("b_disp",   b_dn,     NPIX);
        check("b_fdone",  b_fd_cnt, 1);
        check("b_busy",   b_busy,   1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtx_scheduler.md
RTX_SCHEDULER -- requirements
Module: rtx_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720, frame height in pixels.
REQ-003 SHALL have parameter NUM_CORES, default 4, number of ray_tracer cores scheduled (range 1..16).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse to begin rendering one frame.
REQ-007 SHALL have port busy  output  1  high from accepted start until frame_done.
REQ-008 SHALL have port frame_done  output  1  single-cycle pulse when the last pixel is written.
REQ-009 SHALL have port core_ray_valid  output  [NUM_CORES]  per-core one-cycle dispatch pulse.
REQ-010 SHALL have port core_pixel_h  output  [NUM_CORES][11]  per-core pixel column, stable while the core is occupied.
REQ-011 SHALL have port core_pixel_v  output  [NUM_CORES][10]  per-core pixel row, stable while the core is occupied.
REQ-012 SHALL have port core_ray_done  input  [NUM_CORES]  per-core one-cycle completion pulse.
REQ-013 SHALL have port core_pixel_color  input  [NUM_CORES] x fp24_vec3  per-core result, valid only in its core_ray_done cycle.
REQ-014 SHALL have port fb_we  output  1  framebuffer write request.
REQ-015 SHALL have port fb_addr  output  $clog2(WIDTH*HEIGHT)  write address, v*WIDTH+h.
REQ-016 SHALL have port fb_color  output  fp24_vec3  write data.
REQ-017 SHALL have port fb_ready  input  1  framebuffer accepts; a write transfers when fb_we && fb_ready.

Function
REQ-018 SHALL implement frame FSM IDLE -> RUN (on start) -> DRAIN (after last pixel dispatched) -> DONE (all cores FREE, no write pending) -> IDLE after one cycle.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL keep per-core state FREE -> BUSY (on dispatch) -> HOLD (on core_ray_done) -> FREE (when its result is accepted by the framebuffer).
REQ-021 SHALL dispatch at most one pixel per cycle in RUN, to the lowest-index FREE core, asserting that core's core_ray_valid for exactly one cycle with its coordinates already valid in the same cycle.
REQ-022 SHALL issue pixels in raster order starting (0,0): h increments; at h=WIDTH-1, h wraps to 0 and v increments; dispatch of (WIDTH-1,HEIGHT-1) moves RUN to DRAIN.
REQ-023 SHALL latch core_pixel_color into a per-core holding register in the core_ray_done cycle; simultaneous completions from several cores SHALL all be captured, none dropped.
REQ-024 SHALL ignore core_ray_done from a core not in BUSY.
REQ-025 SHALL select among HOLD cores with a round-robin arbiter, priority starting at the core after the last granted one (core 0 after reset).
REQ-026 SHALL register fb_we/fb_addr/fb_color; once fb_we is high, all three SHALL remain stable until fb_ready; the granted core SHALL return to FREE in the transfer cycle and be eligible for dispatch the next cycle.
REQ-027 SHALL compute fb_addr as v*WIDTH+h from the held coordinates, zero-extended, no truncation.
REQ-028 SHALL allow a new grant in the same cycle a transfer completes (one write per cycle sustained when fb_ready is high).
REQ-029 SHALL pulse frame_done for one cycle in DONE and drop busy in the same cycle.

Reset
REQ-030 SHALL on rst: state IDLE, all cores FREE, busy=0, frame_done=0, core_ray_valid=0, fb_we=0, pixel counters (0,0), round-robin pointer 0; core_pixel_h/v, fb_addr, fb_color = 0.
REQ-031 SHALL on rst mid-frame abandon the frame with no frame_done; cores share the same rst.

Structure
REQ-032 SHALL take fp24_vec3 from the shared rtx package; WIDTH/HEIGHT defaults SHALL match package screen constants.
REQ-033 SHALL use one sub-module, rr_arbiter (NUM_CORES requests, one-hot grant, advance on accept).

Verification
REQ-034 SHALL verify WIDTH=4, HEIGHT=2, NUM_CORES=2, fixed 5-cycle core latency, fb_ready=1 -> 8 writes to addresses 0..7 each exactly once, one frame_done, busy low after.
REQ-035 SHALL verify both cores raising core_ray_done in the same cycle with colors A, B -> two consecutive writes, core 0's then core 1's (pointer 0), both colors intact.
REQ-036 SHALL verify fb_ready held low 10 cycles with fb_we high -> fb_addr/fb_color unchanged, no dispatch to the held core, write completes on release.
REQ-037 SHALL verify start pulsed during RUN -> no effect; pixel sequence and frame_done count unchanged.
REQ-038 SHALL verify rst at pixel 3 of a 4x2 frame, then start -> next frame restarts at (0,0), all 8 addresses written, single frame_done.
REQ-039 SHALL verify NUM_CORES=1, random core latency 1..20 -> raster-order writes, fb_addr = v*4+h for every write.
